// File: rtl/vram_arbiter_if.sv
// Video RAM arbiter bus: video fetch, CPU access, screen-clear
// control and the single-port RAM side, grouped for the arbiter.
interface vram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_data;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              clr_start;
    logic [DATA_W-1:0] clr_char;
    logic              clr_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  clr_start, clr_char, ram_rdata,
        output vid_ack, vid_data, cpu_ack, cpu_rdata, clr_busy,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output clr_start, clr_char, ram_rdata,
        input  vid_ack, vid_data, cpu_ack, cpu_rdata, clr_busy,
        input  ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video > clear > CPU, with a CPU
// starvation counter that lets the CPU overtake a running screen fill.
module vram_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input logic           clk,
    input logic           reset,
    vram_arbiter_if.slave bus
);
    localparam int WAIT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        C_IDLE,
        C_FILL
    } clr_state_t;

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] fill_cnt, fill_cnt_nxt;
    logic [DATA_W-1:0] fill_char, fill_char_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              vid_ack_q, cpu_ack_q;
    logic              vid_ok, cpu_ok, clr_ok, starved;
    logic              gnt_vid, gnt_cpu, gnt_clr;

    // A requester whose ack is due this cycle sits out arbitration.
    always_comb begin
        vid_ok  = !reset && bus.vid_req && !vid_ack_q;
        cpu_ok  = !reset && bus.cpu_req && !cpu_ack_q;
        clr_ok  = !reset && (state == C_FILL);
        starved = (wait_cnt == WAIT_W'(STARVE_MAX));
        gnt_vid = vid_ok;
        gnt_cpu = !vid_ok && cpu_ok && (starved || !clr_ok);
        gnt_clr = !vid_ok && !gnt_cpu && clr_ok;
    end

    always_comb begin
        bus.ram_addr  = addr_q;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        if (gnt_vid) begin
            bus.ram_addr = bus.vid_addr;
        end else if (gnt_cpu) begin
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_we    = bus.cpu_we;
            bus.ram_wdata = bus.cpu_we ? bus.cpu_wdata : '0;
        end else if (gnt_clr) begin
            bus.ram_addr  = fill_cnt;
            bus.ram_we    = 1'b1;
            bus.ram_wdata = fill_char;
        end
    end

    always_comb begin
        state_nxt     = state;
        fill_cnt_nxt  = fill_cnt;
        fill_char_nxt = fill_char;
        unique case (state)
            C_IDLE: begin
                if (bus.clr_start) begin
                    state_nxt     = C_FILL;
                    fill_cnt_nxt  = '0;
                    fill_char_nxt = bus.clr_char;
                end
            end
            C_FILL: begin
                // Last address ends the fill; the counter never wraps.
                if (gnt_clr) begin
                    if (&fill_cnt) state_nxt = C_IDLE;
                    else fill_cnt_nxt = fill_cnt + ADDR_W'(1);
                end
            end
            default: state_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!bus.cpu_req || gnt_cpu) wait_cnt_nxt = '0;
        else if (!starved) wait_cnt_nxt = wait_cnt + WAIT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= C_IDLE;
            fill_cnt  <= '0;
            fill_char <= '0;
            wait_cnt  <= '0;
            addr_q    <= '0;
            vid_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_cnt_nxt;
            fill_char <= fill_char_nxt;
            wait_cnt  <= wait_cnt_nxt;
            addr_q    <= bus.ram_addr;
            vid_ack_q <= gnt_vid;
            cpu_ack_q <= gnt_cpu;
        end
    end

    assign bus.vid_ack   = vid_ack_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.vid_data  = bus.ram_rdata;
    assign bus.cpu_rdata = bus.ram_rdata;
    assign bus.clr_busy  = (state == C_FILL);
endmodule
